// File: rtl/time_keeper_if.sv
// Control and time-of-day bundle between the button front-end, the
// time keeper and the 7-segment display driver.
interface time_keeper_if;
    logic [1:0] select;
    logic       increment;
    logic       decrement;
    logic       mode_12h;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hour_out;
    logic [4:0] hour_disp;
    logic       pm;
    logic       tick_1hz;
    logic       alarm_pulse;

    // Front-end side: drives the buttons and alarm settings, reads the time.
    modport master (
        output select, increment, decrement, mode_12h, alarm_en, alarm_hour, alarm_min,
        input  sec_out, min_out, hour_out, hour_disp, pm, tick_1hz, alarm_pulse
    );

    // Time keeper side.
    modport slave (
        input  select, increment, decrement, mode_12h, alarm_en, alarm_hour, alarm_min,
        output sec_out, min_out, hour_out, hour_disp, pm, tick_1hz, alarm_pulse
    );
endinterface

// File: rtl/time_keeper.sv
// 24h HH:MM:SS clock driven by a clk-derived 1 Hz prescaler, with
// increment/decrement field setting, a 12h display view and a one-shot alarm.
module time_keeper #(
    parameter int unsigned CLK_FREQ_HZ = 1000,
    parameter int unsigned CNT_W       = 32
) (
    input logic          clk,
    input logic          reset_n,
    time_keeper_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [5:0]       sec_q, sec_n;
    logic [5:0]       min_q, min_n;
    logic [4:0]       hour_q, hour_n;
    logic             tick_q, alarm_q, alarm_n;
    logic             inc_q, dec_q;

    logic             inc_evt, dec_evt, one_evt;
    logic             wrap, sec_set, min_set, hour_set, tick;
    logic [5:0]       sec_t, min_t;
    logic [4:0]       hour_t;
    logic             carry_min, carry_hour;

    // Next-state: prescaler, tick carry chain, set overrides and alarm match.
    always_comb begin
        inc_evt  = bus.increment & ~inc_q;
        dec_evt  = bus.decrement & ~dec_q;
        one_evt  = inc_evt ^ dec_evt;
        wrap     = (cnt_q == CNT_MAX);
        sec_set  = one_evt && (bus.select == 2'b00);
        min_set  = one_evt && (bus.select == 2'b01);
        hour_set = one_evt && (bus.select == 2'b10);
        // Clearing seconds restarts the second, so it swallows a coincident tick.
        tick     = wrap && !sec_set;

        cnt_n = (wrap || sec_set) ? '0 : cnt_q + 1'b1;

        carry_min  = (sec_q == 6'd59);
        carry_hour = carry_min && (min_q == 6'd59);
        sec_t  = carry_min ? 6'd0 : sec_q + 6'd1;
        min_t  = carry_min ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) : min_q;
        hour_t = carry_hour ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1) : hour_q;

        sec_n  = sec_set ? 6'd0 : (tick ? sec_t : sec_q);
        min_n  = tick ? min_t : min_q;
        hour_n = tick ? hour_t : hour_q;

        // A set field is computed from its pre-tick value; tick carry into it is dropped.
        if (min_set) begin
            if (inc_evt) min_n = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            else         min_n = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        if (hour_set) begin
            if (inc_evt) hour_n = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            else         hour_n = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end

        // Only a pure tick can fire the alarm; stored fields never exceed range,
        // so out-of-range alarm settings simply never compare equal.
        alarm_n = tick && !min_set && !hour_set && bus.alarm_en &&
                  (hour_n == bus.alarm_hour) && (min_n == bus.alarm_min) &&
                  (sec_n == 6'd0);
    end

    // State registers; edge detectors follow the button levels even in reset.
    always_ff @(posedge clk) begin
        inc_q <= bus.increment;
        dec_q <= bus.decrement;
        if (!reset_n) begin
            cnt_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_n;
            sec_q   <= sec_n;
            min_q   <= min_n;
            hour_q  <= hour_n;
            tick_q  <= tick;
            alarm_q <= alarm_n;
        end
    end

    // 12h display view and pm flag, derived from the 24h hour.
    always_comb begin
        bus.pm = (hour_q >= 5'd12);
        if (!bus.mode_12h)        bus.hour_disp = hour_q;
        else if (hour_q == 5'd0)  bus.hour_disp = 5'd12;
        else if (hour_q > 5'd12)  bus.hour_disp = hour_q - 5'd12;
        else                      bus.hour_disp = hour_q;
    end

    assign bus.sec_out     = sec_q;
    assign bus.min_out     = min_q;
    assign bus.hour_out    = hour_q;
    assign bus.tick_1hz    = tick_q;
    assign bus.alarm_pulse = alarm_q;

endmodule
